// File: rtl/riscv_config_pkg.sv
// rtl/riscv_config_pkg.sv - core-wide default sizing for the divider pool
package riscv_config_pkg;
  localparam int DEFAULT_NUM_DIV_UNITS = 2;
  localparam int DEFAULT_DIV_LATENCY   = 4;
endpackage

// File: rtl/riscv_ooo_types_pkg.sv
// rtl/riscv_ooo_types_pkg.sv - shared out-of-order core types for the divider pool
package riscv_ooo_types_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_unit_state_e;

  // Widths here are upper bounds for tooling/debug views; units size their own registers.
  localparam int DIV_CNT_MAX_W = 8;
  localparam int DIV_TAG_MAX_W = 8;

  typedef struct packed {
    div_unit_state_e            state;
    logic [DIV_CNT_MAX_W-1:0]   counter;
    logic [DIV_TAG_MAX_W-1:0]   tag;
  } div_unit_slot_t;
endpackage

// File: rtl/riscv_div_unit_ctrl.sv
// rtl/riscv_div_unit_ctrl.sv - per-divider IDLE/BUSY/DONE sequencer with countdown and tag register
module riscv_div_unit_ctrl
  import riscv_ooo_types_pkg::*;
#(
  parameter int DIV_LATENCY = 4,
  parameter int TAG_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TAG_W-1:0] start_tag,
  input  logic             flush,
  input  logic             cpl_accept,
  output logic             idle,
  output logic             done,
  output logic [TAG_W-1:0] tag
);

  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  div_unit_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

  // DONE is entered when the decremented count reaches zero, so a grant in
  // cycle t shows DONE in cycle t+DIV_LATENCY (t+1 when the latency is 1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            tag_d   = start_tag;
            cnt_d   = CNT_LOAD;
            state_d = (CNT_LOAD == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) state_d = DONE;
        end
        DONE: begin
          if (cpl_accept) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign idle = (state_q == IDLE);
  assign done = (state_q == DONE);
  assign tag  = tag_q;

endmodule

// File: rtl/riscv_div_sched.sv
// rtl/riscv_div_sched.sv - divider pool issue scheduler; perf counters under RISCV_DIV_SCHED_PERF_EN
module riscv_div_sched
  import riscv_config_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NUM_UNITS   = DEFAULT_NUM_DIV_UNITS,
  parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY,
  parameter int TAG_W       = 6,
  localparam int SEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int UNIT_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_UNITS-1:0]       unit_start_o,
  output logic [NUM_UNITS*SEL_W-1:0] unit_sel_o,
  output logic                       cpl_valid_o,
  output logic [TAG_W-1:0]           cpl_tag_o,
  output logic [UNIT_W-1:0]          cpl_unit_o,
  input  logic                       cpl_ready_i,
  output logic [31:0]                perf_grant_cnt_o,
  output logic [31:0]                perf_stall_cnt_o
);

  logic [SEL_W-1:0]     rr_ptr;
  logic [NUM_UNITS-1:0] unit_idle, unit_done;
  logic [TAG_W-1:0]     unit_tag [NUM_UNITS];
  logic [UNIT_W-1:0]    free_idx, cpl_idx;
  logic                 free_found, cpl_found;
  logic [SEL_W-1:0]     port_idx;
  logic                 port_found;
  logic                 grant;
  logic                 cpl_accept;
  logic [TAG_W-1:0]     grant_tag;

  // Lowest-index IDLE unit for grants and lowest-index DONE unit for completion.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cpl_found  = 1'b0;
    cpl_idx    = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (unit_idle[u]) begin
        free_found = 1'b1;
        free_idx   = UNIT_W'(u);
      end
      if (unit_done[u]) begin
        cpl_found = 1'b1;
        cpl_idx   = UNIT_W'(u);
      end
    end
  end

  // Round-robin: first valid port at or after rr_ptr, wrapping.
  always_comb begin
    int p;
    p          = 0;
    port_found = 1'b0;
    port_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      p = int'(rr_ptr) + i;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      if (req_valid_i[p]) begin
        port_found = 1'b1;
        port_idx   = SEL_W'(p);
      end
    end
  end

  assign grant     = port_found & free_found & ~flush_i;
  assign grant_tag = req_tag_i[port_idx*TAG_W +: TAG_W];

  always_comb begin
    req_ready_o  = '0;
    unit_start_o = '0;
    unit_sel_o   = '0;
    if (grant) begin
      req_ready_o[port_idx]                  = 1'b1;
      unit_start_o[free_idx]                 = 1'b1;
      unit_sel_o[free_idx*SEL_W +: SEL_W]    = port_idx;
    end
  end

  assign cpl_valid_o = cpl_found & ~flush_i;
  assign cpl_tag_o   = cpl_found ? unit_tag[cpl_idx] : '0;
  assign cpl_unit_o  = cpl_idx;
  assign cpl_accept  = cpl_valid_o & cpl_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (port_idx == SEL_W'(NUM_REQ - 1)) ? '0 : port_idx + 1'b1;
    end
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    riscv_div_unit_ctrl #(
      .DIV_LATENCY(DIV_LATENCY),
      .TAG_W      (TAG_W)
    ) u_ctrl (
      .clk       (clk_i),
      .rst       (rst_i),
      .start     (unit_start_o[u]),
      .start_tag (grant_tag),
      .flush     (flush_i),
      .cpl_accept(cpl_accept && (cpl_idx == UNIT_W'(u))),
      .idle      (unit_idle[u]),
      .done      (unit_done[u]),
      .tag       (unit_tag[u])
    );
  end

`ifdef RISCV_DIV_SCHED_PERF_EN
  logic [31:0] grant_cnt, stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant) grant_cnt <= grant_cnt + 32'd1;
      if ((|req_valid_i) && !flush_i && !grant) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_grant_cnt_o = grant_cnt;
  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_grant_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_div_sched.sv
// tb/tb_riscv_div_sched.sv - directed and random checks of riscv_div_sched against a cycle-count model
module tb_riscv_div_sched;
  localparam int NR  = 4;
  localparam int NU  = 2;
  localparam int LAT = 4;
  localparam int TW  = 6;

  logic            clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic [NR-1:0]   req_valid_i = '0;
  logic [NR*TW-1:0] req_tag_i = '0;
  logic [NR-1:0]   req_ready_o;
  logic [NU-1:0]   unit_start_o;
  logic [NU*2-1:0] unit_sel_o;
  logic            cpl_valid_o;
  logic [TW-1:0]   cpl_tag_o;
  logic [0:0]      cpl_unit_o;
  logic            cpl_ready_i = 1'b1;
  logic [31:0]     perf_grant_cnt_o, perf_stall_cnt_o;

  riscv_div_sched #(.NUM_REQ(NR), .NUM_UNITS(NU), .DIV_LATENCY(LAT), .TAG_W(TW)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_tag_i(req_tag_i), .req_ready_o(req_ready_o),
    .unit_start_o(unit_start_o), .unit_sel_o(unit_sel_o),
    .cpl_valid_o(cpl_valid_o), .cpl_tag_o(cpl_tag_o), .cpl_unit_o(cpl_unit_o),
    .cpl_ready_i(cpl_ready_i),
    .perf_grant_cnt_o(perf_grant_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  // Latency-1, single-unit instance for the short-latency and mid-flight reset cases.
  logic            l1_rst = 1'b1;
  logic            l1_flush = 1'b0;
  logic [NR-1:0]   l1_valid = '0;
  logic [NR*TW-1:0] l1_tag = '0;
  logic [NR-1:0]   l1_ready;
  logic [0:0]      l1_start;
  logic [1:0]      l1_sel;
  logic            l1_cv;
  logic [TW-1:0]   l1_ctag;
  logic [0:0]      l1_cu;
  logic            l1_cready = 1'b1;
  logic [31:0]     l1_pg, l1_ps;

  riscv_div_sched #(.NUM_REQ(NR), .NUM_UNITS(1), .DIV_LATENCY(1), .TAG_W(TW)) u_dut_l1 (
    .clk_i(clk_i), .rst_i(l1_rst), .flush_i(l1_flush),
    .req_valid_i(l1_valid), .req_tag_i(l1_tag), .req_ready_o(l1_ready),
    .unit_start_o(l1_start), .unit_sel_o(l1_sel),
    .cpl_valid_o(l1_cv), .cpl_tag_o(l1_ctag), .cpl_unit_o(l1_cu),
    .cpl_ready_i(l1_cready),
    .perf_grant_cnt_o(l1_pg), .perf_stall_cnt_o(l1_ps)
  );

  int checks = 0;
  int errors = 0;

  // Model: each unit is free or holds a tag that becomes completable at an absolute cycle.
  bit          m_busy    [NU];
  logic [TW-1:0] m_tag   [NU];
  int          m_done_at [NU];
  int          m_rr = 0;
  int          cyc = 0;
  int unsigned m_grants = 0;
  int unsigned m_stalls = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    int fr, pt, cu;
    bit g;
    logic [NR-1:0]   e_rdy;
    logic [NU-1:0]   e_st;
    logic [NU*2-1:0] e_sel;
    @(negedge clk_i);
    fr = -1; pt = -1; cu = -1;
    for (int u = 0; u < NU; u++) if (!m_busy[u] && fr < 0) fr = u;
    for (int i = 0; i < NR; i++) if (req_valid_i[(m_rr + i) % NR] && pt < 0) pt = (m_rr + i) % NR;
    for (int u = 0; u < NU; u++) if (m_busy[u] && cyc >= m_done_at[u] && cu < 0) cu = u;
    g = (pt >= 0) && (fr >= 0) && !flush_i;
    e_rdy = '0; e_st = '0; e_sel = '0;
    if (g) begin
      e_rdy[pt] = 1'b1;
      e_st[fr]  = 1'b1;
      e_sel[fr*2 +: 2] = 2'(pt);
    end
    if (!rst_i) begin
      chk("req_ready", req_ready_o, e_rdy);
      chk("unit_start", unit_start_o, e_st);
      chk("unit_sel", unit_sel_o, e_sel);
      chk("cpl_valid", cpl_valid_o, (cu >= 0) && !flush_i);
      chk("cpl_tag", cpl_tag_o, (cu >= 0) ? m_tag[cu] : '0);
      chk("cpl_unit", cpl_unit_o, (cu >= 0) ? cu : 0);
`ifdef RISCV_DIV_SCHED_PERF_EN
      chk("perf_grant", perf_grant_cnt_o, m_grants);
      chk("perf_stall", perf_stall_cnt_o, m_stalls);
`else
      chk("perf_grant", perf_grant_cnt_o, 0);
      chk("perf_stall", perf_stall_cnt_o, 0);
`endif
    end
    @(posedge clk_i);
    if (rst_i) begin
      for (int u = 0; u < NU; u++) begin m_busy[u] = 0; m_tag[u] = '0; end
      m_rr = 0; m_grants = 0; m_stalls = 0;
    end else if (flush_i) begin
      for (int u = 0; u < NU; u++) m_busy[u] = 0;
    end else begin
      if (cu >= 0 && cpl_ready_i) m_busy[cu] = 0;
      if (g) begin
        m_busy[fr]    = 1;
        m_tag[fr]     = req_tag_i[pt*TW +: TW];
        m_done_at[fr] = cyc + LAT;
        m_rr          = (pt + 1) % NR;
        m_grants++;
      end else if (|req_valid_i) begin
        m_stalls++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0; cpl_ready_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [TW-1:0] t);
    req_valid_i[p] = 1'b1;
    req_tag_i[p*TW +: TW] = t;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin m_busy[u] = 0; m_tag[u] = '0; m_done_at[u] = 0; end
    @(posedge clk_i); #1;

    // Reset state, then a single request on port 2.
    do_reset();
    step();
    set_req(2, 6'h15);
    #2;
    chk("s1_ready", req_ready_o, 4'b0100);
    chk("s1_start", unit_start_o, 2'b01);
    chk("s1_sel0", unit_sel_o[1:0], 2);
    step();
    req_valid_i = '0;
    repeat (3) step();
    #2;
    chk("s1_cpl_valid", cpl_valid_o, 1);
    chk("s1_cpl_tag", cpl_tag_o, 6'h15);
    chk("s1_cpl_unit", cpl_unit_o, 0);
    step();
    #2;
    chk("s1_cpl_drop", cpl_valid_o, 0);
    step();

    // All ports requesting continuously.
    do_reset();
    req_valid_i = '1;
    req_tag_i = (NR*TW)'($urandom);
    #2; chk("s2_grant0", req_ready_o, 4'b0001); step();
    #2; chk("s2_grant1", req_ready_o, 4'b0010); step();
    repeat (3) begin #2; chk("s2_nogrant", req_ready_o, 4'b0000); step(); end
    #2; chk("s2_grant2", req_ready_o, 4'b0100);
`ifdef RISCV_DIV_SCHED_PERF_EN
    chk("s2_stall3", perf_stall_cnt_o, 3);
`endif
    step();
    repeat (8) step();
    req_valid_i = '0;

    // Completion backpressure with both units DONE together.
    do_reset();
    set_req(0, 6'h2A);
    step();
    req_valid_i = '0;
    set_req(1, 6'h31);
    step();
    req_valid_i = '0;
    repeat (2) step();
    cpl_ready_i = 1'b0;
    set_req(2, 6'h0C);
    repeat (6) begin
      #2;
      chk("s3_hold_tag", cpl_tag_o, 6'h2A);
      chk("s3_no_regrant", unit_start_o, 2'b00);
      step();
    end
    cpl_ready_i = 1'b1;
    #2; chk("s3_first_unit", cpl_unit_o, 0); step();
    #2;
    chk("s3_second_unit", cpl_unit_o, 1);
    chk("s3_second_tag", cpl_tag_o, 6'h31);
    chk("s3_regrant", req_ready_o, 4'b0100);
    step();
    req_valid_i = '0;
    repeat (6) step();

    // Flush kills in-flight divides.
    do_reset();
    set_req(0, 6'h11);
    set_req(1, 6'h22);
    step();
    step();
    flush_i = 1'b1;
    #2; chk("s5_flush_nogrant", req_ready_o, 4'b0000); step();
    flush_i = 1'b0;
    req_valid_i = '0;
    set_req(3, 6'h33);
    #2;
    chk("s5_post_start", unit_start_o, 2'b01);
    chk("s5_post_ready", req_ready_o, 4'b1000);
    step();
    req_valid_i = '0;
    repeat (6) step();

    // Random traffic.
    repeat (400) begin
      rst_i       = ($urandom % 64) == 0;
      flush_i     = ($urandom % 16) == 0;
      cpl_ready_i = ($urandom % 4) != 0;
      req_valid_i = NR'($urandom);
      req_tag_i   = (NR*TW)'($urandom);
      step();
    end

    // Latency-1 instance.
    rst_i = 1'b1; req_valid_i = '0; flush_i = 1'b0;
    @(posedge clk_i); #1;
    l1_rst = 1'b0;
    l1_valid = 4'b0001; l1_tag[5:0] = 6'h2A;
    #2;
    chk("l1_start", l1_start, 1);
    chk("l1_ready", l1_ready, 4'b0001);
    @(posedge clk_i); #1;
    l1_valid = '0;
    #2;
    chk("l1_cpl_valid", l1_cv, 1);
    chk("l1_cpl_tag", l1_ctag, 6'h2A);
    chk("l1_cpl_unit", l1_cu, 0);
    @(posedge clk_i); #1;
    #2;
    chk("l1_cpl_drop", l1_cv, 0);
    l1_valid = 4'b0001; l1_tag[5:0] = 6'h3C;
    @(posedge clk_i); #1;
    l1_valid = '0;
    l1_rst = 1'b1;
    @(posedge clk_i); #1;
    l1_rst = 1'b0;
    #2;
    chk("l1_rst_cv", l1_cv, 0);
    chk("l1_rst_tag", l1_ctag, 0);
    chk("l1_rst_unit", l1_cu, 0);
    chk("l1_rst_ready", l1_ready, 0);
    chk("l1_rst_start", l1_start, 0);
    chk("l1_rst_sel", l1_sel, 0);
    chk("l1_rst_pg", l1_pg, 0);
    l1_valid = 4'b0010;
    #1;
    chk("l1_rst_regrant", l1_start, 1);
    chk("l1_rst_rr", l1_ready, 4'b0010);
    @(posedge clk_i); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
